// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the cpu_loader program loader.
package cpu_loader_pkg;

    localparam int unsigned ARM_CYCLES = 2;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM,
        S_ROM_LO,
        S_ROM_HI,
        S_ARM,
        S_RUN,
        S_DISARM,
        S_DONE
    } loader_state_e;

endpackage

// File: rtl/cpu_mem.sv
// Data RAM and instruction ROM for the cpu core: one write port each and
// combinational reads. Arrays are deliberately not reset.
module cpu_mem #(
    parameter int unsigned IW = 16,
    parameter int unsigned PW = 8,
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          ram_we,
    input  logic [AW-1:0] ram_waddr,
    input  logic [DW-1:0] ram_wdata,
    input  logic          rom_we,
    input  logic [PW-1:0] rom_waddr,
    input  logic [IW-1:0] rom_wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic [PW-1:0] pc,
    output logic [IW-1:0] inst
);

    localparam int unsigned RAM_DEPTH = 1 << AW;
    localparam int unsigned ROM_DEPTH = 1 << PW;

    logic [DW-1:0] ram_mem [RAM_DEPTH];
    logic [IW-1:0] rom_mem [ROM_DEPTH];

    // RAM write port (loader or core, already arbitrated)
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_waddr] <= ram_wdata;
        end
    end

    // ROM write port (loader only)
    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom_mem[rom_waddr] <= rom_wdata;
        end
    end

    assign rdata = ram_mem[raddr];
    assign inst  = rom_mem[pc];

endmodule

// File: rtl/cpu_loader.sv
// Program loader and memory responder for the cpu core: streams bytes into
// RAM then ROM, runs the core via setn until idle, then pulses done.
// Optional run watchdog: define CPU_LOADER_WATCHDOG_EN.
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned IMSB       = 15,
    parameter int unsigned PMSB       = 7,
    parameter int unsigned AMSB       = 7,
    parameter int unsigned DMSB       = 7,
    parameter int unsigned WDT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              setn,
    input  logic              idle,
    input  logic              write,
    input  logic [DMSB:0]     wdata,
    input  logic [AMSB:0]     addr,
    output logic [DMSB:0]     rdata,
    input  logic [PMSB:0]     pc,
    output logic [IMSB:0]     inst
);

    localparam int unsigned IW   = IMSB + 1;
    localparam int unsigned PW   = PMSB + 1;
    localparam int unsigned AW   = AMSB + 1;
    localparam int unsigned DW   = DMSB + 1;
    localparam int unsigned PH_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    loader_state_e     state;
    logic [AW-1:0]     ram_cnt;
    logic [PW-1:0]     rom_cnt;
    logic [BYTE_W-1:0] lo_byte;
    logic [PH_W-1:0]   ph_cnt;

    logic              accept_c;
    logic              ram_we_c;
    logic [AW-1:0]     ram_waddr_c;
    logic [DW-1:0]     ram_wdata_c;
    logic              rom_we_c;
    logic [IW-1:0]     rom_wdata_c;

`ifdef CPU_LOADER_WATCHDOG_EN
    localparam int unsigned WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    logic [WW-1:0] wdt_cnt;
`else
    localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign accept_c = s_valid & s_ready;

    // Load/arm/run/disarm sequencer with registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            ram_cnt <= '0;
            rom_cnt <= '0;
            lo_byte <= '0;
            ph_cnt  <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            setn    <= 1'b0;
`ifdef CPU_LOADER_WATCHDOG_EN
            timeout <= 1'b0;
            wdt_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RAM;
                        ram_cnt <= '0;
                        rom_cnt <= '0;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
`ifdef CPU_LOADER_WATCHDOG_EN
                        timeout <= 1'b0;
`endif
                    end
                end
                S_RAM: begin
                    if (accept_c) begin
                        ram_cnt <= ram_cnt + AW'(1);
                        if (ram_cnt == '1) begin
                            state <= S_ROM_LO;
                        end
                    end
                end
                S_ROM_LO: begin
                    if (accept_c) begin
                        lo_byte <= s_data;
                        state   <= S_ROM_HI;
                    end
                end
                S_ROM_HI: begin
                    if (accept_c) begin
                        rom_cnt <= rom_cnt + PW'(1);
                        if (rom_cnt == '1) begin
                            state   <= S_ARM;
                            s_ready <= 1'b0;
                            ph_cnt  <= '0;
                        end else begin
                            state <= S_ROM_LO;
                        end
                    end
                end
                S_ARM: begin
                    if (ph_cnt == PH_W'(ARM_CYCLES - 1)) begin
                        state <= S_RUN;
                        setn  <= 1'b1;
`ifdef CPU_LOADER_WATCHDOG_EN
                        wdt_cnt <= '0;
`endif
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                S_RUN: begin
                    if (idle) begin
                        state  <= S_DISARM;
                        setn   <= 1'b0;
                        ph_cnt <= '0;
                    end
`ifdef CPU_LOADER_WATCHDOG_EN
                    else if (wdt_cnt == WW'(WDT_CYCLES - 1)) begin
                        state   <= S_DISARM;
                        setn    <= 1'b0;
                        ph_cnt  <= '0;
                        timeout <= 1'b1;
                    end else begin
                        wdt_cnt <= wdt_cnt + WW'(1);
                    end
`endif
                end
                S_DISARM: begin
                    if (ph_cnt == PH_W'(ARM_CYCLES - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    setn    <= 1'b0;
                end
            endcase
        end
    end

    // Memory write arbitration: loader during load states, core only while setn
    always_comb begin
        ram_we_c    = 1'b0;
        ram_waddr_c = addr;
        ram_wdata_c = wdata;
        rom_we_c    = 1'b0;
        if (state == S_RAM && accept_c) begin
            ram_we_c    = 1'b1;
            ram_waddr_c = ram_cnt;
            ram_wdata_c = DW'(s_data);
        end else if (setn && write) begin
            ram_we_c = 1'b1;
        end
        if (state == S_ROM_HI && accept_c) begin
            rom_we_c = 1'b1;
        end
    end

    // ROM word is little-endian: high byte arrives second
    assign rom_wdata_c = IW'({s_data, lo_byte});

    cpu_mem #(
        .IW (IW),
        .PW (PW),
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk       (clk),
        .ram_we    (ram_we_c),
        .ram_waddr (ram_waddr_c),
        .ram_wdata (ram_wdata_c),
        .rom_we    (rom_we_c),
        .rom_waddr (rom_cnt),
        .rom_wdata (rom_wdata_c),
        .raddr     (addr),
        .rdata     (rdata),
        .pc        (pc),
        .inst      (inst)
    );

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboard bench for cpu_loader: stimulus pushes expectations, a negedge
// monitor pops and compares them, and tracks each run to its done pulse.
module tb_cpu_loader;

`ifdef CPU_LOADER_WATCHDOG_EN
    localparam int unsigned WDT = 50;
`else
    localparam int unsigned WDT = 1000;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        setn;
    logic        idle;
    logic        write;
    logic [7:0]  wdata;
    logic [7:0]  addr;
    logic [7:0]  rdata;
    logic [7:0]  pc;
    logic [15:0] inst;

    cpu_loader #(
        .IMSB       (15),
        .PMSB       (7),
        .AMSB       (7),
        .DMSB       (7),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .setn    (setn),
        .idle    (idle),
        .write   (write),
        .wdata   (wdata),
        .addr    (addr),
        .rdata   (rdata),
        .pc      (pc),
        .inst    (inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;   // 0 rdata,1 inst,2 s_ready,3 busy,4 setn,5 timeout,6 done,7 given value
        logic [15:0] exp;
        logic [15:0] act;
    } probe_t;

    typedef struct {
        int run_len;
        int gap;
        bit tmo;
    } run_t;

    probe_t probe_q[$];
    run_t   run_q[$];
    int     errors = 0;
    int     checks = 0;

    // Monitor: compares queued probes and scores every run ending in done
    initial begin
        probe_t      p;
        run_t        r;
        logic [15:0] act;
        bit          in_run   = 0;
        bit          chk_low  = 0;
        int          run_len  = 0;
        int          gap      = 0;
        forever begin
            @(negedge clk);
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                case (p.sel)
                    0:       act = 16'(rdata);
                    1:       act = inst;
                    2:       act = 16'(s_ready);
                    3:       act = 16'(busy);
                    4:       act = 16'(setn);
                    5:       act = 16'(timeout);
                    6:       act = 16'(done);
                    default: act = p.act;
                endcase
                checks++;
                if (act !== p.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", p.name, act, p.exp);
                end
            end
            if (!rstn) begin
                in_run  = 0;
                chk_low = 0;
            end else begin
                if (chk_low) begin
                    checks++;
                    if (done !== 1'b0) begin
                        errors++;
                        $display("FAIL done_width: done still %b one cycle after pulse", done);
                    end
                    chk_low = 0;
                end
                if (setn) begin
                    if (!in_run) begin
                        in_run  = 1;
                        run_len = 0;
                        gap     = 0;
                    end
                    run_len++;
                end else if (in_run) begin
                    gap++;
                end
                if (done) begin
                    if (run_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done with no sequence expected");
                    end else begin
                        r = run_q.pop_front();
                        checks += 3;
                        if (run_len != r.run_len) begin
                            errors++;
                            $display("FAIL run_len: got %0d setn cycles, expected %0d", run_len, r.run_len);
                        end
                        if (gap != r.gap) begin
                            errors++;
                            $display("FAIL done_gap: got %0d, expected %0d", gap, r.gap);
                        end
                        if (timeout !== r.tmo) begin
                            errors++;
                            $display("FAIL run_timeout: got %b, expected %b", timeout, r.tmo);
                        end
                    end
                    in_run  = 0;
                    chk_low = 1;
                end
            end
        end
    end

    // Queue a live-signal probe and let the monitor sample it
    task automatic probe(input string name, input int sel, input logic [15:0] exp);
        probe_t p;
        p.name = name;
        p.sel  = sel;
        p.exp  = exp;
        p.act  = 16'h0;
        probe_q.push_back(p);
        @(negedge clk);
        #1;
    endtask

    // Queue a comparison of a value the stimulus has already measured
    task automatic check_val(input string name, input logic [15:0] exp, input logic [15:0] act);
        probe_t p;
        p.name = name;
        p.sel  = 7;
        p.exp  = exp;
        p.act  = act;
        probe_q.push_back(p);
    endtask

    task automatic expect_run(input int run_len, input int gap, input bit tmo);
        run_t r;
        r.run_len = run_len;
        r.gap     = gap;
        r.tmo     = tmo;
        run_q.push_back(r);
    endtask

    task automatic probe_ram(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a;
        probe(name, 0, 16'(exp));
    endtask

    task automatic probe_rom(input string name, input logic [7:0] a, input logic [15:0] exp);
        pc = a;
        probe(name, 1, exp);
    endtask

    // Byte idx of the load stream: RAM bytes i^key, then ROM words little-endian
    function automatic logic [7:0] stream_byte(input int idx, input logic [7:0] key);
        logic [15:0] w;
        int          k;
        if (idx < 256) return 8'(idx) ^ key;
        k = idx - 256;
        w = (k / 2 == 0) ? 16'h0000 : (16'h8000 | 16'(k / 2));
        return (k % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Stream nbytes bytes; returns number of cycles with s_ready high
    task automatic stream(input bit toggle, input logic [7:0] key, input int nbytes,
                          output int cycles, output bit ok);
        int idx;
        int n;
        bit v;
        bit rdy;
        idx    = 0;
        n      = 0;
        cycles = 0;
        while (idx < nbytes && n < 4000) begin
            v       = toggle ? (n % 2 == 0) : 1'b1;
            s_valid = v;
            s_data  = stream_byte(idx, key);
            rdy     = s_ready;
            if (rdy) cycles++;
            @(posedge clk);
            #1;
            if (v && rdy) idx++;
            n++;
        end
        s_valid = 1'b0;
        ok      = (idx == nbytes);
    endtask

    // Cycles from the last-byte cycle to the first setn cycle
    task automatic measure_arm();
        int k;
        k = 1;
        while (!setn && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val("arm_latency", 16'd3, 16'(k));
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            check_val(name, 16'd1, 16'd0);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cycles;
        bit ok;

        rstn    = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        idle    = 1'b1;
        write   = 1'b0;
        wdata   = 8'h00;
        addr    = 8'h00;
        pc      = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        probe("rst_s_ready", 2, 16'd0);
        probe("rst_busy",    3, 16'd0);
        probe("rst_done",    6, 16'd0);
        probe("rst_setn",    4, 16'd0);
        probe("rst_timeout", 5, 16'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Sequence A: full load with s_valid held, immediate idle
        idle = 1'b1;
        pulse_start();
        check_val("a_busy_start", 16'd1, 16'(busy));
        expect_run(1, 3, 1'b0);
        stream(1'b0, 8'h5A, 768, cycles, ok);
        check_val("a_load_ok",      16'd1,   16'(ok));
        check_val("a_load_cycles",  16'd768, 16'(cycles));
        check_val("a_s_ready_drop", 16'd0,   16'(s_ready));
        measure_arm();
        wait_done("a_wait_done");
        probe("a_busy_after", 3, 16'd0);
        probe_ram("a_ram_10", 8'h10, 8'h4A);
        probe_ram("a_ram_00", 8'h00, 8'h5A);
        probe_ram("a_ram_ff", 8'hFF, 8'hA5);
        probe_rom("a_rom_03", 8'h03, 16'h8003);
        probe_rom("a_rom_00", 8'h00, 16'h0000);
        probe_rom("a_rom_ff", 8'hFF, 16'h80FF);
        // Core write while setn=0 must not land
        @(posedge clk);
        #1;
        write = 1'b1;
        addr  = 8'h21;
        wdata = 8'h00;
        @(posedge clk);
        #1 write = 1'b0;
        probe_ram("a_ram_21_nowrite", 8'h21, 8'h7B);

        // Sequence B: back-pressured load, core write during run, start ignored
        idle = 1'b0;
        pulse_start();
        expect_run(2, 3, 1'b0);
        stream(1'b1, 8'h5A, 768, cycles, ok);
        check_val("b_load_ok",     16'd1,    16'(ok));
        check_val("b_load_cycles", 16'd1535, 16'(cycles));
        measure_arm();
        write = 1'b1;
        addr  = 8'h20;
        wdata = 8'h7E;
        start = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        start = 1'b0;
        idle  = 1'b1;
        probe_ram("b_core_write", 8'h20, 8'h7E);
        probe("b_busy_start_ignored", 3, 16'd1);
        wait_done("b_wait_done");
        probe_ram("b_ram_10", 8'h10, 8'h4A);
        probe_rom("b_rom_03", 8'h03, 16'h8003);

        // Sequence C: reset after 100 RAM bytes with a different key
        pulse_start();
        stream(1'b0, 8'hC3, 100, cycles, ok);
        check_val("c_partial_ok", 16'd1, 16'(ok));
        rstn = 1'b0;
        #1;
        check_val("c_rst_setn",    16'd0, 16'(setn));
        check_val("c_rst_busy",    16'd0, 16'(busy));
        check_val("c_rst_s_ready", 16'd0, 16'(s_ready));
        @(posedge clk);
        #1 rstn = 1'b1;
        probe_ram("c_ram_00",  8'd0,   8'hC3);
        probe_ram("c_ram_50",  8'd50,  8'hF1);
        probe_ram("c_ram_99",  8'd99,  8'hA0);
        probe_ram("c_ram_100", 8'd100, 8'h3E);

`ifdef CPU_LOADER_WATCHDOG_EN
        // Sequence D: core never idles, watchdog ends the run
        idle = 1'b0;
        pulse_start();
        expect_run(50, 3, 1'b1);
        stream(1'b0, 8'h5A, 768, cycles, ok);
        check_val("d_load_ok", 16'd1, 16'(ok));
        measure_arm();
        wait_done("d_wait_done");
        probe("d_timeout_sticky", 5, 16'd1);
        pulse_start();
        check_val("d_timeout_cleared", 16'd0, 16'(timeout));
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_loader.md
# cpu_loader

Program loader and memory responder for the `cpu` core. It holds the data RAM and instruction ROM and answers the core's `addr`/`write`/`wdata`/`rdata` and `pc`/`inst` ports. A byte stream fills RAM and then ROM. The block then raises `setn` to run the core until `idle`, and drops `setn` again. This moves the load/run sequencing out of the bench and into synthesizable RTL.

## Interface
- `IMSB`, 15: instruction MSB; ROM word width is IMSB+1.
- `PMSB`, 7: program-counter MSB; ROM depth is 2^(PMSB+1).
- `AMSB`, 7: data-address MSB; RAM depth is 2^(AMSB+1).
- `DMSB`, 7: data MSB; RAM width is DMSB+1 and must be 7.
- `WDT_CYCLES`, 1000: run-cycle limit. Used only with `CPU_LOADER_WATCHDOG_EN`.
- `clk  in  1`: the only clock.
- `rstn  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle pulse that begins a load/run sequence.
- `s_valid  in  1`: stream byte valid.
- `s_data  in  8`: stream byte.
- `s_ready  out  1`: block accepts the byte this cycle.
- `busy  out  1`: a sequence is in progress.
- `done  out  1`: one-cycle pulse when a sequence completes.
- `timeout  out  1`: sticky watchdog flag, cleared by `start`.
- `setn  out  1`: run enable to the core.
- `idle  in  1`: core halted.
- `write  in  1`, `wdata  in  DMSB+1`, `addr  in  AMSB+1`: core data-write port.
- `rdata  out  DMSB+1`: RAM[addr], combinational read.
- `pc  in  PMSB+1`: core program counter.
- `inst  out  IMSB+1`: ROM[pc], combinational read.

## Operation
- FSM states:
  - **S_IDLE**: waits for `start`.
  - **S_RAM**: loads RAM.
  - **S_ROM_LO**, **S_ROM_HI**: load ROM low and high bytes.
  - **S_ARM**: two cycles with `setn`=0.
  - **S_RUN**: `setn`=1.
  - **S_DISARM**: two cycles with `setn`=0.
  - **S_DONE**: one cycle, asserts `done`, then returns to S_IDLE.
- **S_IDLE**: `start` moves to S_RAM. The RAM counter and ROM counter are zeroed and `timeout` is cleared.
- **S_RAM**:
  - `s_ready`=1.
  - Each accepted byte (`s_valid` and `s_ready`) is written to RAM[counter], then the counter increments.
  - After byte 2^(AMSB+1)-1, move to S_ROM_LO.
- **S_ROM_LO**: an accepted byte is latched as the low byte. Move to S_ROM_HI.
- **S_ROM_HI**:
  - An accepted byte forms ROM[counter] = {byte, low byte}; the word is little-endian, upper bits beyond 16 are zero.
  - The counter increments.
  - After word 2^(PMSB+1)-1, move to S_ARM; otherwise return to S_ROM_LO.
- `s_ready`=0 outside S_RAM, S_ROM_LO and S_ROM_HI.
- **S_RUN**:
  - Lasts at least one cycle.
  - Exits to S_DISARM on the first posedge after entry at which `idle`=1.
  - While `setn`=1, a core write (`write`=1) stores RAM[addr] <= `wdata` at posedge.
- `busy`=1 in every state except S_IDLE.
- `start` while `busy` is ignored.
- `s_valid` with no byte accepted (`s_ready`=0) does not consume the byte.
- Counters wrap naturally, but no state ever accepts more bytes than the memory depth.

## Timing
- Reset values: S_IDLE; `setn`=0, `s_ready`=0, `busy`=0, `done`=0, `timeout`=0; counters 0.
- Memory arrays are not cleared by reset.
- Reset mid-load or mid-run returns to S_IDLE immediately and drops `setn` asynchronously. Already-written memory words are kept.
- Load writes take effect at the posedge of acceptance and are visible on `rdata`/`inst` in the next cycle.
- Full load with `s_valid` held high: 2^(AMSB+1) + 2·2^(PMSB+1) cycles (768 at defaults).
- From the last ROM byte to `setn`=1: S_ARM plus one cycle, i.e. 3 cycles.
- From `idle` sampled high to `done`: 3 cycles.
- `done` is high for exactly one cycle.
- Core writes and loader writes never coincide, because `setn`=0 whenever the loader writes.

## Configuration
- `CPU_LOADER_WATCHDOG_EN` defined:
  - A counter clears on S_RUN entry and increments each S_RUN cycle.
  - When it reaches `WDT_CYCLES` with `idle`=0, `timeout` is set and the FSM goes to S_DISARM.
  - `done` still pulses.
- `CPU_LOADER_WATCHDOG_EN` undefined: no counter; `timeout` is tied to 0; S_RUN is unbounded.

## Structure
- `cpu_loader_pkg` holds:
  - the state enum `loader_state_e`;
  - ARM/DISARM length constant = 2;
  - byte width constant = 8.
- Sub-module `cpu_mem`: RAM and ROM arrays with two write ports (RAM write with address and data, ROM write) and two combinational reads.
- Write arbitration (loader vs. core) lives in `cpu_loader`.

## Test plan
- **Load check**: stream RAM bytes i^0x5A for i=0..255, then ROM words 0x8000|i. Check `rdata` at addr 0x10 = 0x4A and `inst` at pc 0x03 = 0x8003. Check `s_ready` drops after byte 767.
- **Back-pressure**: toggle `s_valid` every other cycle. Same contents; load completes in 1535 cycles.
- **Run**: ROM word 0 = 0x0000, so `idle` is asserted immediately. Require `setn` high for exactly 1 cycle, `done` 3 cycles later, `timeout`=0.
- **Core write**: drive `write`=1, `addr`=0x20, `wdata`=0x7E during S_RUN. Expect `rdata`=0x7E at addr 0x20 on the next cycle. `write` while `setn`=0 leaves RAM unchanged.
- **Reset mid-load**: drop `rstn` after 100 RAM bytes. Require `setn`=0, `busy`=0 and `s_ready`=0 immediately. RAM[0..99] retained.
- **Watchdog**, macro defined with `WDT_CYCLES`=50: hold `idle`=0. Expect `timeout`=1 after 50 run cycles, then `done`. A new `start` clears `timeout`.
